// File: rtl/alu_issue.sv
// RV32I decode/issue stage feeding the ALU (OP, OP-IMM, LUI, AUIPC) through one output register.
// Define ALU_ISSUE_ILLEGAL_TRAP_EN to issue illegal instructions flagged instead of dropping them.
`ifndef ADD
`define ADD  4'd0
`endif
`ifndef SUB
`define SUB  4'd1
`endif
`ifndef SLL
`define SLL  4'd2
`endif
`ifndef SLT
`define SLT  4'd3
`endif
`ifndef SLTU
`define SLTU 4'd4
`endif
`ifndef XOR
`define XOR  4'd5
`endif
`ifndef SRL
`define SRL  4'd6
`endif
`ifndef SRA
`define SRA  4'd7
`endif
`ifndef OR
`define OR   4'd8
`endif
`ifndef AND
`define AND  4'd9
`endif

module alu_issue #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [XLEN-1:0]  in_pc,
    output logic [4:0]       rs1_addr,
    output logic [4:0]       rs2_addr,
    input  logic [XLEN-1:0]  rs1_data,
    input  logic [XLEN-1:0]  rs2_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [3:0]       op,
    output logic [XLEN-1:0]  d1,
    output logic [XLEN-1:0]  d2,
    output logic [4:0]       rd,
    output logic             wb_en,
    output logic             illegal,
    output logic [CNT_W-1:0] issue_cnt
);

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [3:0]      dec_op;
    logic [XLEN-1:0] dec_d1, dec_d2;
    logic            dec_legal;

    logic             valid_q, valid_d;
    logic [3:0]       op_q, op_d;
    logic [XLEN-1:0]  d1_q, d1_d, d2_q, d2_d;
    logic [4:0]       rd_q, rd_d;
    logic             wb_en_q, wb_en_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             in_hs, out_hs, load;

    assign opcode   = in_instr[6:0];
    assign funct3   = in_instr[14:12];
    assign funct7   = in_instr[31:25];
    assign rs1_addr = in_instr[19:15];
    assign rs2_addr = in_instr[24:20];

    // Illegal encodings fall through with op=ADD, d1=d2=0, which is exactly the trap payload.
    always_comb begin
        dec_op    = `ADD;
        dec_d1    = '0;
        dec_d2    = '0;
        dec_legal = 1'b0;
        unique case (opcode)
            OPC_OP: begin
                if (funct7 == 7'b0000000) begin
                    dec_legal = 1'b1;
                    unique case (funct3)
                        3'b000:  dec_op = `ADD;
                        3'b001:  dec_op = `SLL;
                        3'b010:  dec_op = `SLT;
                        3'b011:  dec_op = `SLTU;
                        3'b100:  dec_op = `XOR;
                        3'b101:  dec_op = `SRL;
                        3'b110:  dec_op = `OR;
                        default: dec_op = `AND;
                    endcase
                end else if (funct7 == 7'b0100000 && funct3 == 3'b000) begin
                    dec_legal = 1'b1;
                    dec_op    = `SUB;
                end else if (funct7 == 7'b0100000 && funct3 == 3'b101) begin
                    dec_legal = 1'b1;
                    dec_op    = `SRA;
                end
                if (dec_legal) begin
                    dec_d1 = rs1_data;
                    dec_d2 = rs2_data;
                end
            end
            OPC_OP_IMM: begin
                unique case (funct3)
                    3'b001: begin
                        dec_legal = (funct7 == 7'b0000000);
                        dec_op    = dec_legal ? `SLL : `ADD;
                    end
                    3'b101: begin
                        dec_legal = (funct7 == 7'b0000000) || (funct7 == 7'b0100000);
                        dec_op    = !dec_legal ? `ADD : (in_instr[30] ? `SRA : `SRL);
                    end
                    3'b000:  begin dec_legal = 1'b1; dec_op = `ADD;  end
                    3'b010:  begin dec_legal = 1'b1; dec_op = `SLT;  end
                    3'b011:  begin dec_legal = 1'b1; dec_op = `SLTU; end
                    3'b100:  begin dec_legal = 1'b1; dec_op = `XOR;  end
                    3'b110:  begin dec_legal = 1'b1; dec_op = `OR;   end
                    default: begin dec_legal = 1'b1; dec_op = `AND;  end
                endcase
                if (dec_legal) begin
                    dec_d1 = rs1_data;
                    if (funct3 == 3'b001 || funct3 == 3'b101)
                        dec_d2 = XLEN'(in_instr[24:20]);
                    else
                        dec_d2 = XLEN'(signed'(in_instr[31:20]));
                end
            end
            OPC_LUI: begin
                dec_legal = 1'b1;
                dec_d2    = XLEN'(signed'({in_instr[31:12], 12'b0}));
            end
            OPC_AUIPC: begin
                dec_legal = 1'b1;
                dec_d1    = in_pc;
                dec_d2    = XLEN'(signed'({in_instr[31:12], 12'b0}));
            end
            default: ;
        endcase
    end

    assign in_ready = !valid_q || out_ready;
    assign in_hs    = in_valid && in_ready;
    assign out_hs   = valid_q && out_ready;
`ifdef ALU_ISSUE_ILLEGAL_TRAP_EN
    assign load = in_hs;
`else
    assign load = in_hs && dec_legal;
`endif

    always_comb begin
        valid_d = valid_q;
        op_d    = op_q;
        d1_d    = d1_q;
        d2_d    = d2_q;
        rd_d    = rd_q;
        wb_en_d = wb_en_q;
        cnt_d   = cnt_q + CNT_W'(out_hs);
        if (load) begin
            valid_d = 1'b1;
            op_d    = dec_op;
            d1_d    = dec_d1;
            d2_d    = dec_d2;
            rd_d    = dec_legal ? in_instr[11:7] : 5'd0;
            wb_en_d = dec_legal && (in_instr[11:7] != 5'd0);
        end else if (out_hs) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= 1'b0;
            op_q    <= `ADD;
            d1_q    <= '0;
            d2_q    <= '0;
            rd_q    <= '0;
            wb_en_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            valid_q <= valid_d;
            op_q    <= op_d;
            d1_q    <= d1_d;
            d2_q    <= d2_d;
            rd_q    <= rd_d;
            wb_en_q <= wb_en_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef ALU_ISSUE_ILLEGAL_TRAP_EN
    logic illegal_q;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            illegal_q <= 1'b0;
        else if (load)
            illegal_q <= !dec_legal;
    end
    assign illegal = illegal_q;
`else
    assign illegal = 1'b0;
`endif

    assign out_valid = valid_q;
    assign op        = op_q;
    assign d1        = d1_q;
    assign d2        = d2_q;
    assign rd        = rd_q;
    assign wb_en     = wb_en_q;
    assign issue_cnt = cnt_q;

endmodule
